// File: rtl/msb_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready
// handshake and emits them MSB-first with first/last framing flags.
module msb_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_first,
  output logic             dout_last,
  output logic             dbg_state_o
);

  // Handshake: a word transfers on a rising edge where din_valid and
  // din_ready are both 1; din is sampled only then. din_ready is low exactly
  // while the hold register is occupied.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             acc;

  assign acc = din_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          sh_d    = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (acc) begin
            hold_d   = din;
            hold_v_d = 1'b1;
          end
        end else if (hold_v_q) begin
          // ready is low while hold is full, so no transfer competes here
          sh_d     = hold_q;
          hold_v_d = 1'b0;
          cnt_d    = '0;
        end else if (acc) begin
          sh_d  = din;
          cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flags describe the bit presented by the current state.
  always_comb begin
    dout_d  = (state_q == SHIFT) & sh_q[WIDTH-1];
    valid_d = (state_q == SHIFT);
    first_d = (state_q == SHIFT) && (cnt_q == '0);
    last_d  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    ready_d = ~hold_v_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      dout_q   <= 1'b0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  assign din_ready   = ready_q;
  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign dout_first  = first_q;
  assign dout_last   = last_q;
  assign dbg_state_o = (state_q == SHIFT);

endmodule

// File: tb/tb_msb_serializer.sv
// Bench for msb_serializer: directed vectors, corner sequences and random
// traffic, all checked every cycle against a bit-queue reference model.
module tb_msb_serializer;
  localparam int WIDTH = 8;

  logic             clk;
  logic             resetn;
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             din_ready;
  logic             dout;
  logic             dout_valid;
  logic             dout_first;
  logic             dout_last;
  logic             dbg_state;

  msb_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_first (dout_first),
    .dout_last  (dout_last),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: every accepted word appends its WIDTH bits {bit,first,last}
  // to a queue; each clock edge presents the next queued bit, with a word
  // accepted on that edge queued behind it. A word is waiting in the hold
  // register whenever more than one word's worth of bits is outstanding.
  logic [2:0]       bq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_d, exp_v, exp_f, exp_l, exp_rdy;
  logic [WIDTH-1:0] rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("din_ready", 32'(din_ready), 32'(exp_rdy));
    check("dout_valid", 32'(dout_valid), 32'(exp_v));
    check("dout", 32'(dout), 32'(exp_d));
    check("dout_first", 32'(dout_first), 32'(exp_f));
    check("dout_last", 32'(dout_last), 32'(exp_l));
  endtask

  task automatic clear_model();
    bq.delete();
    exp_q.delete();
    rx = '0;
    {exp_d, exp_v, exp_f, exp_l, exp_rdy} = '0;
  endtask

  // One clock: sample handshake, advance model on the edge, check #1 later.
  task automatic step();
    logic             acc;
    logic [WIDTH-1:0] din_s;
    logic [2:0]       e;
    acc   = din_valid && din_ready && resetn;
    din_s = din;
    @(posedge clk);
    if (resetn) begin
      if (bq.size() > 0) begin
        e = bq.pop_front();
        {exp_d, exp_f, exp_l} = e;
        exp_v = 1'b1;
      end else begin
        {exp_d, exp_v, exp_f, exp_l} = '0;
      end
      if (acc) begin
        for (int i = WIDTH - 1; i >= 0; i--)
          bq.push_back({din_s[i], i == WIDTH - 1, i == 0});
        exp_q.push_back(din_s);
      end
      exp_rdy = (bq.size() <= WIDTH);
    end
    #1;
    check_outputs();
    if (dout_valid) begin
      rx = {rx[WIDTH-2:0], dout};
      if (dout_last) begin
        if (exp_q.size() == 0) check("word_unexpected", 32'(rx), 32'hFFFF_FFFF);
        else check("word", 32'(rx), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic assert_reset();
    resetn = 1'b0;
    #1;
    clear_model();
    check_outputs();
  endtask

  task automatic drain();
    int budget;
    din_valid = 1'b0;
    budget = 0;
    while ((bq.size() > 0 || dout_valid) && budget < 4 * WIDTH) begin
      step();
      budget++;
    end
    if (budget >= 4 * WIDTH) check("drain_timeout", 32'(budget), 32'(0));
    step();
  endtask

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] bits;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int first_at, last_at, low_cycles, nvalid, widx, budget;
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] words[3];

    vecs[0] = '{word: 8'hB4, bits: 8'b1011_0100};
    vecs[1] = '{word: 8'h03, bits: 8'b0000_0011};
    vecs[2] = '{word: 8'h81, bits: 8'b1000_0001};
    vecs[3] = '{word: 8'h5A, bits: 8'b0101_1010};
    vecs[4] = '{word: 8'hFF, bits: 8'b1111_1111};

    din_valid = 1'b0;
    din       = '0;
    resetn    = 1'b0;
    clear_model();
    #1;
    check_outputs();
    step();
    step();
    #2 resetn = 1'b1;
    step();
    check("ready_after_reset", 32'(din_ready), 32'(1));

    // table: single word from idle
    foreach (vecs[v]) begin
      din = vecs[v].word;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      din = '0;
      got = '0;
      first_at = -1;
      last_at = -1;
      for (int c = 0; c < WIDTH; c++) begin
        step();
        got = {got[WIDTH-2:0], dout};
        if (dout_first) first_at = c;
        if (dout_last) last_at = c;
      end
      check("vec_bits", 32'(got), 32'(vecs[v].bits));
      check("vec_first_pos", 32'(first_at), 32'(0));
      check("vec_last_pos", 32'(last_at), 32'(WIDTH - 1));
      step();
      check("vec_idle_after", 32'(dout_valid), 32'(0));
    end

    // streaming 03 then FF
    din = 8'h03;
    din_valid = 1'b1;
    step();
    din = 8'hFF;
    nvalid = 0;
    budget = 0;
    while (din_ready == 1'b0 || din_valid) begin
      step();
      if (dout_valid) nvalid++;
      if (din_valid && exp_q.size() >= 2) din_valid = 1'b0;
      budget++;
      if (budget > 4 * WIDTH) break;
      if (!din_valid) break;
    end
    while (dout_valid && budget < 4 * WIDTH) begin
      step();
      if (dout_valid) nvalid++;
      budget++;
    end
    check("stream_valid_bits", 32'(nvalid), 32'(2 * WIDTH));
    drain();

    // backpressure: three words, garbage on din while not ready
    words[0] = 8'hA5;
    words[1] = 8'h5A;
    words[2] = 8'h0F;
    widx = 0;
    low_cycles = 0;
    nvalid = 0;
    din = words[0];
    din_valid = 1'b1;
    budget = 0;
    while (widx < 3 && budget < 10 * WIDTH) begin
      logic was_acc;
      was_acc = din_ready;
      step();
      if (dout_valid) nvalid++;
      if (was_acc) widx++;
      if (widx >= 3) din_valid = 1'b0;
      else if (!din_ready) begin
        din = WIDTH'($urandom);
        low_cycles++;
      end else din = words[widx];
      budget++;
    end
    check("bp_all_accepted", 32'(widx), 32'(3));
    check("bp_ready_low_seen", 32'(low_cycles > 0), 32'(1));
    while (dout_valid && budget < 10 * WIDTH) begin
      step();
      if (dout_valid) nvalid++;
      budget++;
    end
    check("bp_bits_out", 32'(nvalid), 32'(3 * WIDTH));
    drain();

    // direct load in the last-bit cycle with hold empty
    din = 8'h3C;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < WIDTH - 1; c++) step();
    din = 8'h81;
    din_valid = 1'b1;
    step();
    check("lastbit_last", 32'(dout_last), 32'(1));
    check("lastbit_ready", 32'(din_ready), 32'(1));
    check("lastbit_accepted", 32'(exp_q.size()), 32'(1));
    din_valid = 1'b0;
    step();
    check("lastbit_first", 32'(dout_first), 32'(1));
    check("lastbit_msb", 32'(dout), 32'(1));
    drain();

    // reset mid-word with a held word
    din = 8'hC3;
    din_valid = 1'b1;
    step();
    din = 8'h3C;
    step();
    check("mid_hold_full", 32'(din_ready), 32'(0));
    din_valid = 1'b0;
    step();
    step();
    assert_reset();
    check("mid_reset_valid", 32'(dout_valid), 32'(0));
    step();
    step();
    #2 resetn = 1'b1;
    #1 check("mid_ready_before_edge", 32'(din_ready), 32'(0));
    nvalid = 0;
    for (int c = 0; c < 3 * WIDTH; c++) begin
      step();
      if (dout_valid) nvalid++;
    end
    check("mid_no_resume", 32'(nvalid), 32'(0));

    // reset with din_valid high throughout
    din = 8'h96;
    din_valid = 1'b1;
    assert_reset();
    step();
    step();
    #2 resetn = 1'b1;
    step();
    check("rv_no_acc_in_reset", 32'(exp_q.size()), 32'(0));
    check("rv_ready_rise", 32'(din_ready), 32'(1));
    step();
    check("rv_accepted", 32'(exp_q.size()), 32'(1));
    check("rv_valid_low", 32'(dout_valid), 32'(0));
    din_valid = 1'b0;
    step();
    check("rv_first_bit", 32'(dout_valid & dout_first), 32'(1));
    drain();

    // random traffic, occasional resets
    for (int c = 0; c < 2500; c++) begin
      if (din_valid && !din_ready && $urandom_range(0, 1) == 0) begin
        // keep presenting the same word
      end else begin
        din_valid = ($urandom_range(0, 3) != 0);
        din = WIDTH'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        step();
        #2 resetn = 1'b1;
      end
      step();
    end
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/msb_serializer.md
# msb_serializer

Parallel-to-serial front end for the bit-serial mod-3 detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, with framing flags. A one-entry hold buffer lets consecutive words stream with no idle cycles between them. dout feeds the detector's serial input, and dout_first marks each word boundary so the integration can restart the detector per word.

## Interface
- WIDTH, 8, word width in bits; legal for WIDTH ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- din_valid  in  1  upstream word present.
- din  in  WIDTH  upstream word; bit WIDTH-1 is sent first.
- din_ready  out  1  block can accept a word this cycle; registered.
- dout  out  1  serial bit; registered.
- dout_valid  out  1  dout carries a word bit this cycle.
- dout_first  out  1  dout is bit WIDTH-1 (the MSB) of a word.
- dout_last  out  1  dout is bit 0 (the LSB) of a word.

## Operation
- Storage:
  - shift register sh[WIDTH-1:0];
  - bit counter cnt, sized ceil(log2(WIDTH)), counting 0..WIDTH-1;
  - hold register hold[WIDTH-1:0] with flag hold_v;
  - state, either IDLE or SHIFT.
- A transfer (acc) occurs on a rising edge where din_valid and din_ready are both 1.
- Registered ready: din_ready at the next edge = NOT hold_v_next.
- IDLE, output side: dout_valid=0, dout=0, dout_first=0, dout_last=0.
- IDLE, on acc: load sh=din, set cnt=0, go to SHIFT.
- SHIFT, output side (registered): dout=sh[WIDTH-1], dout_valid=1, dout_first=(cnt==0), dout_last=(cnt==WIDTH-1).
- SHIFT with cnt<WIDTH-1: shift sh left by 1 and increment cnt. On acc, write hold=din and set hold_v=1.
- SHIFT with cnt==WIDTH-1 (last bit):
  - if hold_v: load sh=hold, clear hold_v, set cnt=0, stay in SHIFT. din_ready is 0 this cycle, so no acc can occur.
  - else if acc: load sh=din directly, set cnt=0, stay in SHIFT.
  - else: go to IDLE.
- Throughput: with din_valid held high, output is 100% valid bits and WIDTH cycles per word.
- Backpressure: din_ready is 0 exactly while hold_v=1. Upstream must hold din and din_valid stable until acc.
- din is sampled only on acc. din changes while din_ready=0 have no effect.

## Timing
- Reset values while resetn=0, applied immediately (asynchronous):
  - din_ready=0, dout=0, dout_valid=0, dout_first=0, dout_last=0;
  - state=IDLE, hold_v=0, cnt=0, sh=0.
- Reset release: din_ready rises at the first rising edge after resetn goes high. din_valid asserted during reset is never accepted.
- Latency: a word accepted in IDLE at edge k drives its MSB at edge k+1 (dout_first=1) and its LSB at edge k+WIDTH (dout_last=1).
- Back-to-back: the next word's MSB follows the previous LSB on the very next cycle, whether it comes from the hold register or by direct load.
- Reset mid-word: the current word and any held word are discarded. No partial word is ever resumed or emitted after reset.
- dout_first and dout_last are never both 1, because WIDTH ≥ 2.
- Exactly WIDTH dout_valid cycles are produced per accepted word, in acceptance order. No word is lost or duplicated.

## Test plan
- Single word, WIDTH=8: din=8'hB4 accepted at edge 0.
  - Required: dout=1,0,1,1,0,1,0,0 on edges 1–8.
  - dout_first=1 only at edge 1; dout_last=1 only at edge 8; dout_valid=0 from edge 9.
- Streaming: 8'h03 then 8'hFF with din_valid held high.
  - Required: 16 contiguous valid bits 00000011 11111111.
  - dout_first at edges 1 and 9; dout_last at edges 8 and 16.
- Backpressure: three words 8'hA5, 8'h5A, 8'h0F presented continuously.
  - Required: din_ready=0 while the hold register is full, and the third word waits.
  - All 24 bits come out in order with no bubble; din is not sampled while din_ready=0.
- Last-bit direct load: hold empty, a word 8'h81 arrives exactly in the last-bit cycle.
  - Required: it is accepted, and its MSB follows on the next cycle with dout_first=1.
- Reset mid-word: resetn is pulled low after 3 bits of 8'hC3 while 8'h3C is held.
  - Required: all outputs go to 0 immediately, and din_ready=0 until the first edge after release.
  - After release, neither 8'hC3 nor 8'h3C appears on dout.
- Reset with din_valid=1 throughout: the word is not accepted before din_ready=1, and dout_valid stays 0 until one cycle after the first acc.
